// File: rtl/regfile_dualread_pkg.sv
// Shared register-file constants: architectural register numbers and ALU overflow codes.
// The processor and the test bench import the same values from here.
package regfile_dualread_pkg;

  localparam int REG_ZERO   = 0;
  localparam int REG_STATUS = 30;
  localparam int REG_RA     = 31;
  localparam int REG_ADDR_W = 5;

  // Codes the ALU path writes into REG_STATUS on overflow.
  localparam int OVF_ADD  = 1;
  localparam int OVF_ADDI = 2;
  localparam int OVF_SUB  = 3;

endpackage

// File: rtl/register_en.sv
// WIDTH-bit storage register with write enable and synchronous clear.
// Clear takes priority over enable.
module register_en #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (ctrl_reset) begin
      q_d = '0;
    end else if (enable) begin
      q_d = d;
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_dualread.sv
// Register file with 32 registers, two combinational read ports and one write port.
// r0 always reads zero; BYPASS forwards the write data to a matching read in the same cycle.
module regfile_dualread
  import regfile_dualread_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 0
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [REG_ADDR_W-1:0] ctrl_writeReg,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegA,
  input  logic [REG_ADDR_W-1:0] ctrl_readRegB,
  input  logic [WIDTH-1:0]      data_writeReg,
  output logic [WIDTH-1:0]      data_readRegA,
  output logic [WIDTH-1:0]      data_readRegB
);

  localparam logic [REG_ADDR_W-1:0] ADDR_ZERO = REG_ADDR_W'(REG_ZERO);

  logic [NREGS-1:1] wr_sel;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             byp_a;
  logic             byp_b;

  // One-hot write decode; there is no select line for r0, so its writes vanish.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < NREGS; i++) begin
      wr_sel[i] = ctrl_writeEnable && (ctrl_writeReg == i[REG_ADDR_W-1:0]);
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_reg
    register_en #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .enable     (wr_sel[g]),
      .d          (data_writeReg),
      .q          (regs[g])
    );
  end

  always_comb begin
    rd_a = regs[ctrl_readRegA];
    rd_b = regs[ctrl_readRegB];
  end

  // Forwarding never applies to r0, so a zero read address still returns zero.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (BYPASS != 0 && ctrl_writeEnable && !ctrl_reset && ctrl_writeReg != ADDR_ZERO) begin
      byp_a = (ctrl_writeReg == ctrl_readRegA);
      byp_b = (ctrl_writeReg == ctrl_readRegB);
    end
  end

  assign data_readRegA = byp_a ? data_writeReg : rd_a;
  assign data_readRegB = byp_b ? data_writeReg : rd_b;

endmodule

// File: tb/tb_regfile_dualread.sv
// Self-checking bench: one instance without and one with bypass, driven identically and
// compared against an array model of the 32 architectural registers.
module tb_regfile_dualread;
  import regfile_dualread_pkg::*;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;

  logic [31:0] model [32];
  int errors = 0;
  int checks = 0;

  regfile_dualread #(.WIDTH(32), .NREGS(32), .BYPASS(0)) dut0 (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(rd_a0), .data_readRegB(rd_b0)
  );

  regfile_dualread #(.WIDTH(32), .NREGS(32), .BYPASS(1)) dut1 (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_writeReg(data_writeReg), .data_readRegA(rd_a1), .data_readRegB(rd_b1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] expect_rd(input logic [4:0] addr, input bit bypass);
    if (addr == 5'd0) return 32'h0;
    if (bypass && ctrl_writeEnable && !ctrl_reset && ctrl_writeReg == addr) return data_writeReg;
    return model[addr];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compares all four read outputs for the current addresses and pending write.
  task automatic check_ports(input string tag);
    #2;
    chk($sformatf("%s nobyp A[%0d]", tag, ctrl_readRegA), rd_a0, expect_rd(ctrl_readRegA, 1'b0));
    chk($sformatf("%s nobyp B[%0d]", tag, ctrl_readRegB), rd_b0, expect_rd(ctrl_readRegB, 1'b0));
    chk($sformatf("%s byp A[%0d]", tag, ctrl_readRegA), rd_a1, expect_rd(ctrl_readRegA, 1'b1));
    chk($sformatf("%s byp B[%0d]", tag, ctrl_readRegB), rd_b1, expect_rd(ctrl_readRegB, 1'b1));
  endtask

  // Advances one edge and applies the architectural effect of the inputs held across it.
  task automatic tick();
    @(posedge clock);
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (ctrl_writeEnable && ctrl_writeReg != 5'd0) begin
      model[ctrl_writeReg] = data_writeReg;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      check_ports(tag);
    end
  endtask

  initial begin
    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = 5'd0;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    data_writeReg = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;

    tick();
    tick();
    ctrl_reset = 1'b0;
    sweep("reset");

    write_reg(5'd1, 32'h0000000B);
    write_reg(5'(REG_STATUS), 32'(OVF_ADD));
    write_reg(5'(REG_RA), 32'hDEADBEEF);
    ctrl_readRegA = 5'd1;  ctrl_readRegB = 5'(REG_RA);
    check_ports("wr_rd");
    chk("r1 literal", rd_a0, 32'h0000000B);
    chk("r31 literal", rd_b0, 32'hDEADBEEF);
    ctrl_readRegA = 5'(REG_STATUS); ctrl_readRegB = 5'(REG_STATUS);
    check_ports("status");
    chk("r30 literal", rd_a0, 32'h00000001);
    sweep("after_wr");

    write_reg(5'd0, 32'hFFFFFFFF);
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    check_ports("r0");
    chk("r0 literal", rd_a1, 32'h0);
    sweep("after_r0");

    ctrl_writeEnable = 1'b0;
    ctrl_writeReg = 5'd5;
    data_writeReg = 32'h12345678;
    tick();
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd5;
    check_ports("we_low");
    chk("r5 literal", rd_a0, 32'h0);

    write_reg(5'd2, 32'd5);
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd2; data_writeReg = 32'd7;
    ctrl_readRegA = 5'd2; ctrl_readRegB = 5'd0;
    check_ports("same_cycle");
    chk("nobyp pre-edge literal", rd_a0, 32'd5);
    chk("byp pre-edge literal", rd_a1, 32'd7);
    chk("byp r0 port literal", rd_b1, 32'd0);
    tick();
    ctrl_writeEnable = 1'b0;
    check_ports("post_edge");
    chk("nobyp post-edge literal", rd_a0, 32'd7);

    ctrl_reset = 1'b1;
    ctrl_writeEnable = 1'b1; ctrl_writeReg = 5'd3; data_writeReg = 32'h55AA55AA;
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd3;
    check_ports("rst_wr_pre");
    tick();
    ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0;
    ctrl_readRegA = 5'd3; ctrl_readRegB = 5'd1;
    check_ports("collision");
    chk("r3 literal", rd_a1, 32'h0);
    chk("r1 cleared literal", rd_b0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      ctrl_reset       = ($urandom_range(0, 39) == 0);
      ctrl_writeEnable = $urandom_range(0, 3) != 0;
      ctrl_writeReg    = 5'($urandom_range(0, 31));
      data_writeReg    = $urandom;
      ctrl_readRegA    = ($urandom_range(0, 2) == 0) ? ctrl_writeReg : 5'($urandom_range(0, 31));
      ctrl_readRegB    = ($urandom_range(0, 3) == 0) ? ctrl_readRegA : 5'($urandom_range(0, 31));
      check_ports("rand");
      tick();
    end
    ctrl_reset = 1'b0; ctrl_writeEnable = 1'b0;
    sweep("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
